// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled UART receiver (5-8 data bits, optional parity, 1/2 stop); UART_RX_MAJORITY_EN enables 3-sample voting.
// Latency 16T*(N+P+S)+8T+1 clocks from start detect (+T with voting); no backpressure, rx_done is a one-cycle strobe.
module uart_rx_os #(
    parameter int OVS   = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_start,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [3:0]       length,
    input  logic             parity_en,
    input  logic             parity_type,
    input  logic             stop2,
    output logic [7:0]       rx_out,
    output logic             rx_done,
    output logic             parity_err,
    output logic             frame_err
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DEC_PT = 4'd8;
`else
    localparam logic [3:0] DEC_PT = 4'd7;
`endif
    localparam logic [3:0] LAST_OS = 4'(OVS - 1);

    state_t           state, state_nxt;
    logic             rx_s1, rx_s2;
    logic [DIV_W-1:0] div_cnt, div_l;
    logic [3:0]       os_cnt, bit_cnt, len_l;
    logic             par_en_l, par_type_l, stop2_l;
    logic [7:0]       shreg;
    logic             par_err_i, frm_err_i;
    logic             running, tick, sample_pt, bit_end, start_go, bit_val, exp_par;
    logic             shift_en, par_chk, stop_chk;

`ifdef UART_RX_MAJORITY_EN
    logic s6, s7;
    assign bit_val = (s6 & s7) | (s6 & rx_s2) | (s7 & rx_s2);
`else
    assign bit_val = rx_s2;
`endif

    assign running   = (state != IDLE) && (state != DONE);
    assign tick      = running && (div_cnt == div_l);
    assign sample_pt = tick && (os_cnt == DEC_PT);
    assign bit_end   = tick && (os_cnt == LAST_OS);
    assign start_go  = (state == IDLE) && rx_start && !rx_s2;
    assign exp_par   = par_type_l ? ^shreg : ~^shreg;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_go) state_nxt = START;
            START: begin
                if (sample_pt && bit_val) state_nxt = IDLE;
                else if (bit_end)         state_nxt = DATA;
            end
            DATA:   if (bit_end && (bit_cnt == len_l - 4'd1))
                        state_nxt = par_en_l ? PARITY : STOP1;
            PARITY: if (bit_end) state_nxt = STOP1;
            STOP1: begin
                if (stop2_l) begin
                    if (bit_end) state_nxt = STOP2;
                end else if (sample_pt) begin
                    state_nxt = DONE;
                end
            end
            STOP2:  if (sample_pt) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_en = (state == DATA) && sample_pt;
        par_chk  = (state == PARITY) && sample_pt;
        stop_chk = ((state == STOP1) || (state == STOP2)) && sample_pt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            div_cnt    <= '0;
            div_l      <= '0;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            len_l      <= 4'd8;
            par_en_l   <= 1'b0;
            par_type_l <= 1'b0;
            stop2_l    <= 1'b0;
            shreg      <= '0;
            par_err_i  <= 1'b0;
            frm_err_i  <= 1'b0;
            rx_out     <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            s6         <= 1'b1;
            s7         <= 1'b1;
`endif
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_done <= (state == DONE);

            // Config is frozen for the whole frame at start detection.
            if (start_go) begin
                div_l      <= baud_div;
                len_l      <= ((length >= 4'd5) && (length <= 4'd8)) ? length : 4'd8;
                par_en_l   <= parity_en;
                par_type_l <= parity_type;
                stop2_l    <= stop2;
                div_cnt    <= '0;
                os_cnt     <= '0;
                bit_cnt    <= '0;
                shreg      <= '0;
                par_err_i  <= 1'b0;
                frm_err_i  <= 1'b0;
            end else if (tick) begin
                div_cnt <= '0;
                os_cnt  <= os_cnt + 4'd1;
            end else if (running) begin
                div_cnt <= div_cnt + 1'b1;
            end

`ifdef UART_RX_MAJORITY_EN
            if (tick && (os_cnt == 4'd6)) s6 <= rx_s2;
            if (tick && (os_cnt == 4'd7)) s7 <= rx_s2;
`endif

            if ((state == DATA) && bit_end) bit_cnt <= bit_cnt + 4'd1;
            if (shift_en)                   shreg   <= {bit_val, shreg[7:1]};
            if (par_chk)                    par_err_i <= (bit_val != exp_par);
            if (stop_chk && !bit_val)       frm_err_i <= 1'b1;

            // Data was shifted in from the top, so right-align by the unused bit count.
            if (state == DONE) begin
                rx_out     <= shreg >> (4'd8 - len_l);
                parity_err <= par_err_i;
                frame_err  <= frm_err_i;
            end
        end
    end

endmodule
